alu_scheduler: RTL

Time-shares the single 5-bit combinational ALU (op 0 = add, op 1 = subtract, R and ZF outputs) between two independent requesters. Each request is an operand pair plus an op. The block arbitrates round-robin, drives the ALU from registered operands, captures R/ZF, and returns the result to the winning requester. It replaces the fixed operand-generating FSM in front of the ALU when more than one source needs it.

---
 rtl/alu_sched_pkg.sv | 16 +
 rtl/rr_arb2.sv | 13 +
 rtl/alu_scheduler.sv | 120 ++++++++++++
 3 files changed

// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the two-requester ALU scheduler.
// Holds the FSM state encoding, the default datapath width and the ALU op codes.
package alu_sched_pkg;

    localparam int DEF_WIDTH = 5;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick: a lone request wins outright,
// and on a tie the requester that was not served last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       valid,
    output logic       winner
);

    assign valid  = |req;
    assign winner = (req == 2'b11) ? ~last_grant : req[1];

endmodule

// File: rtl/alu_scheduler.sv
// Time-shares one external combinational ALU between two requesters:
// IDLE arbitrates and latches operands, EXEC lets the ALU settle, DONE returns the result.
module alu_scheduler
    import alu_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             op0,
    output logic             ack0,
    output logic             done0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             op1,
    output logic             ack1,
    output logic             done1,
    output logic [WIDTH-1:0] res,
    output logic             zf,
    output logic             busy,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_op,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_zf
);

    state_t           state_q, state_d;
    logic             gnt_q, gnt_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic             alu_op_q, alu_op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zf_q, zf_d;

    logic             arb_valid;
    logic             arb_winner;

    rr_arb2 u_arb (
        .req        ({req1, req0}),
        .last_grant (last_grant_q),
        .valid      (arb_valid),
        .winner     (arb_winner)
    );

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latch).
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        res_d        = res_q;
        zf_d         = zf_q;

        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d  = EXEC;
                    gnt_d    = arb_winner;
                    alu_a_d  = arb_winner ? a1  : a0;
                    alu_b_d  = arb_winner ? b1  : b0;
                    alu_op_d = arb_winner ? op1 : op0;
                end
            end
            EXEC: begin
                res_d   = alu_r;
                zf_d    = alu_zf;
                state_d = DONE;
            end
            DONE: begin
                last_grant_d = gnt_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= OP_ADD;
            res_q        <= '0;
            zf_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            res_q        <= res_d;
            zf_q         <= zf_d;
        end
    end

    // Handshake pulses decode straight from state, so they vanish the instant reset asserts.
    assign ack0   = (state_q == EXEC) && !gnt_q;
    assign ack1   = (state_q == EXEC) &&  gnt_q;
    assign done0  = (state_q == DONE) && !gnt_q;
    assign done1  = (state_q == DONE) &&  gnt_q;
    assign busy   = (state_q != IDLE);
    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign alu_op = alu_op_q;
    assign res    = res_q;
    assign zf     = zf_q;

endmodule
